// File: rtl/dma_host_programmer.sv
// dma_host_programmer: expands cfg/readback commands into byte-sequenced 8237 slave-bus accesses
module dma_host_programmer #(
  parameter int STROBE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_channel,
  input  logic [15:0] cfg_base_addr,
  input  logic [15:0] cfg_word_count,
  input  logic [5:0]  cfg_mode,
  input  logic        cfg_unmask,
  output logic        cfg_done,
  input  logic        rd_valid,
  input  logic [1:0]  rd_channel,
  output logic        rd_data_valid,
  output logic [15:0] rd_data,
  output logic [3:0]  address,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  output logic        CS_N,
  output logic        IOR_N,
  output logic        IOW_N
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  localparam logic [3:0] LAST_STB = 4'(STROBE_CYCLES - 1);
  state_t state, nextState;
  logic [3:0] stbCnt, regSel;
  logic [2:0] step;
  logic [1:0] ch;
  logic [15:0] baseAddr, wordCount, rdBuf;
  logic [5:0] mode;
  logic [7:0] wrData;
  logic isRd, unmask, accept, lastStep, stbDone, isWrite;
  always_comb begin
    accept = cfg_ready && (cfg_valid || rd_valid);
    lastStep = step == (isRd ? 3'd2 : unmask ? 3'd6 : 3'd5);
    stbDone = stbCnt == LAST_STB;
    // only the byte-pointer clear of a readback is a write
    isWrite = !isRd || step == 3'd0;
    regSel = step == 3'd0 ? 4'hC :
             step <= 3'd2 ? {1'b0, ch, 1'b0} :
             step <= 3'd4 ? {1'b0, ch, 1'b1} :
             step == 3'd5 ? 4'hB : 4'hA;
    wrData = (isRd || step == 3'd0) ? 8'h00 :
             step == 3'd1 ? baseAddr[7:0] :
             step == 3'd2 ? baseAddr[15:8] :
             step == 3'd3 ? wordCount[7:0] :
             step == 3'd4 ? wordCount[15:8] :
             step == 3'd5 ? {mode, ch} : {6'b0, ch};
    nextState = state == IDLE   ? (accept ? SETUP : IDLE) :
                state == SETUP  ? STROBE :
                state == STROBE ? (stbDone ? HOLD : STROBE) :
                (lastStep ? IDLE : SETUP);
    CS_N = state == IDLE;
    data_oe = state != IDLE && isWrite;
    IOW_N = !(state == STROBE && isWrite);
    IOR_N = !(state == STROBE && !isWrite);
    address = state == IDLE ? 4'h0 : regSel;
    data_out = data_oe ? wrData : 8'h00;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      stbCnt <= '0;
      step <= '0;
      isRd <= 1'b0;
      unmask <= 1'b0;
      ch <= '0;
      baseAddr <= '0;
      wordCount <= '0;
      mode <= '0;
      rdBuf <= '0;
      rd_data <= '0;
      cfg_ready <= 1'b1;
      cfg_done <= 1'b0;
      rd_data_valid <= 1'b0;
    end else begin
      state <= nextState;
      stbCnt <= (state == STROBE && !stbDone) ? stbCnt + 4'd1 : 4'd0;
      cfg_done <= state == HOLD && lastStep && !isRd;
      rd_data_valid <= state == HOLD && lastStep && isRd;
      if (accept) begin
        cfg_ready <= 1'b0;
        isRd <= !cfg_valid;
        ch <= cfg_valid ? cfg_channel : rd_channel;
        baseAddr <= cfg_base_addr;
        wordCount <= cfg_word_count;
        mode <= cfg_mode;
        unmask <= cfg_unmask;
        step <= '0;
      end else if (cfg_done || rd_data_valid) cfg_ready <= 1'b1;
      if (state == HOLD && !lastStep) step <= step + 3'd1;
      if (state == STROBE && stbDone && isRd && step == 3'd1) rdBuf[7:0] <= data_in;
      if (state == STROBE && stbDone && isRd && step == 3'd2) rdBuf[15:8] <= data_in;
      if (state == HOLD && lastStep && isRd) rd_data <= rdBuf;
    end
  end
endmodule

// File: tb/tb_dma_host_programmer.sv
// tb_dma_host_programmer: access-list timing model plus 8237 slave model, run on STROBE_CYCLES 2, 1 and 4 builds
module tb_dma_host_programmer;
  localparam int SCS [3] = '{2, 1, 4};
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic cfg_valid = 0, rd_valid = 0, cfg_unmask = 0;
  logic [1:0] cfg_channel = 0, rd_channel = 0;
  logic [15:0] cfg_base_addr = 0, cfg_word_count = 0;
  logic [5:0] cfg_mode = 0;
  logic [7:0] data_in;
  int sel = 0, total = 0, bad = 0;
  logic rdyA [3], doneA [3], rdvA [3], oeA [3], csA [3], iorA [3], iowA [3];
  logic [15:0] rdA [3];
  logic [3:0] adA [3];
  logic [7:0] doA [3];
  for (genvar g = 0; g < 3; g++) begin : gd
    dma_host_programmer #(.STROBE_CYCLES(SCS[g])) u (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid && sel == g), .cfg_ready(rdyA[g]), .cfg_channel(cfg_channel),
      .cfg_base_addr(cfg_base_addr), .cfg_word_count(cfg_word_count), .cfg_mode(cfg_mode),
      .cfg_unmask(cfg_unmask), .cfg_done(doneA[g]),
      .rd_valid(rd_valid && sel == g), .rd_channel(rd_channel),
      .rd_data_valid(rdvA[g]), .rd_data(rdA[g]),
      .address(adA[g]), .data_out(doA[g]), .data_oe(oeA[g]), .data_in(data_in),
      .CS_N(csA[g]), .IOR_N(iorA[g]), .IOW_N(iowA[g]));
  end
  logic rdy, done, rdv, oe, cs, ior, iow;
  logic [15:0] rd;
  logic [3:0] ad;
  logic [7:0] dout;
  assign {rdy, done, rdv, oe, cs, ior, iow} = {rdyA[sel], doneA[sel], rdvA[sel], oeA[sel], csA[sel], iorA[sel], iowA[sel]};
  assign rd = rdA[sel];
  assign ad = adA[sel];
  assign dout = doA[sel];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // 8237 slave: byte-pointer flip-flop, current-address registers, write log
  typedef struct packed {logic [3:0] a; logic [7:0] d;} wr_t;
  wr_t wq [$];
  logic [15:0] cur [4];
  logic ff = 0, pIow = 1, pIor = 1;
  int iorCnt = 0;
  assign data_in = (!cs && !ior) ? (ff ? cur[ad[2:1]][15:8] : cur[ad[2:1]][7:0]) : 8'h00;
  always @(posedge clk) begin
    pIow <= iow;
    pIor <= ior;
    if (!rst && !pIow && iow) begin
      wq.push_back('{ad, dout});
      if (ad == 4'hC) ff <= 0;
      else if (!ad[3]) begin
        if (!ad[0] && ff) cur[ad[2:1]][15:8] <= dout;
        if (!ad[0] && !ff) cur[ad[2:1]][7:0] <= dout;
        ff <= ~ff;
      end
    end
    if (!rst && !pIor && ior) begin
      ff <= ~ff;
      iorCnt++;
    end
  end

  // model: list of expected accesses, each SC+2 cycles, done one cycle after the last
  logic [3:0] ea [7];
  logic [7:0] ed [7];
  logic ew [7];
  logic [15:0] shadow [4], rdExp = 0, mAddr;
  logic [1:0] mCh;
  logic mRd;
  int k = 0, n = 0, mper, msc, acc, ph;
  logic stb;
  always @(negedge clk) begin
    msc = SCS[sel];
    mper = msc + 2;
    if (rst) begin
      k = 0;
      rdExp = 0;
      chk("rst_cs", cs, 1); chk("rst_ior", ior, 1); chk("rst_iow", iow, 1); chk("rst_oe", oe, 0);
      chk("rst_rdy", rdy, 1); chk("rst_done", done, 0); chk("rst_rdv", rdv, 0); chk("rst_rd", rd, 0);
      chk("rst_ad", ad, 0); chk("rst_do", dout, 0);
    end else if (k == 0) begin
      chk("idle_cs", cs, 1); chk("idle_ior", ior, 1); chk("idle_iow", iow, 1); chk("idle_oe", oe, 0);
      chk("idle_rdy", rdy, 1); chk("idle_done", done, 0); chk("idle_rdv", rdv, 0); chk("idle_rd", rd, rdExp);
      if (cfg_valid || rd_valid) begin
        mRd = !cfg_valid;
        mCh = cfg_valid ? cfg_channel : rd_channel;
        mAddr = cfg_base_addr;
        ea[0] = 4'hC; ed[0] = 8'h00; ew[0] = 1;
        ea[1] = {1'b0, mCh, 1'b0}; ea[2] = ea[1];
        ea[3] = {1'b0, mCh, 1'b1}; ea[4] = ea[3];
        ea[5] = 4'hB; ea[6] = 4'hA;
        ed[1] = cfg_base_addr[7:0]; ed[2] = cfg_base_addr[15:8];
        ed[3] = cfg_word_count[7:0]; ed[4] = cfg_word_count[15:8];
        ed[5] = {cfg_mode, mCh}; ed[6] = {6'b0, mCh};
        for (int i = 1; i < 7; i++) ew[i] = !mRd;
        n = mRd ? 3 : cfg_unmask ? 7 : 6;
        k = 1;
      end
    end else if (k <= n * mper) begin
      acc = (k - 1) / mper;
      ph = (k - 1) % mper;
      stb = ph >= 1 && ph <= msc;
      chk("acc_cs", cs, 0); chk("acc_oe", oe, ew[acc]);
      chk("acc_iow", iow, !(ew[acc] && stb)); chk("acc_ior", ior, !(!ew[acc] && stb));
      chk("acc_ad", ad, ea[acc]);
      if (ew[acc]) chk("acc_do", dout, ed[acc]);
      chk("acc_rdy", rdy, 0); chk("acc_done", done, 0); chk("acc_rdv", rdv, 0);
      k++;
    end else begin
      if (mRd) rdExp = shadow[mCh];
      else shadow[mCh] = mAddr;
      chk("fin_cs", cs, 1); chk("fin_oe", oe, 0); chk("fin_iow", iow, 1); chk("fin_ior", ior, 1);
      chk("fin_rdy", rdy, 0); chk("fin_done", done, !mRd); chk("fin_rdv", rdv, mRd); chk("fin_rd", rd, rdExp);
      k = 0;
    end
  end

  task automatic waitEv(input int w, output int t);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(w == 0 ? rdy : w == 1 ? done : rdv) && c < 400);
    t = int'($time / 10);
    if (!(w == 0 ? rdy : w == 1 ? done : rdv)) begin
      total++;
      bad++;
      $display("FAIL timeout waiting ev%0d", w);
    end
  endtask

  task automatic setCfg(input logic [1:0] c, input logic [15:0] a, input logic [15:0] w, input logic [5:0] m, input logic u);
    cfg_channel = c; cfg_base_addr = a; cfg_word_count = w; cfg_mode = m; cfg_unmask = u;
  endtask

  logic [11:0] expWr [7] = '{12'hC00, 12'h434, 12'h412, 12'h5FF, 12'h500, 12'hB5A, 12'hA02};
  int tA, tD, tR, per;
  initial begin
    cur[0] = 16'h0000; cur[1] = 16'hABCD; cur[2] = 16'h1111; cur[3] = 16'h2222;
    for (int i = 0; i < 4; i++) shadow[i] = cur[i];
    for (int s = 0; s < 3; s++) begin
      sel = s;
      per = SCS[s] + 2;
      rst = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      wq.delete();
      setCfg(2'd2, 16'h1234, 16'h00FF, 6'b010110, 1);
      cfg_valid = 1;
      waitEv(0, tA);
      @(posedge clk); #1 cfg_valid = 0;
      waitEv(1, tD);
      chk("lat7", 16'(tD - tA), 16'(7 * per + 1));
      if (s == 0) chk("lat29", 16'(tD - tA), 16'd29);
      chk("nwr7", 16'(wq.size()), 16'd7);
      for (int i = 0; i < 7 && i < wq.size(); i++) chk($sformatf("wr%0d", i), 16'(wq[i]), 16'(expWr[i]));
      wq.delete();
      cfg_unmask = 0;
      cfg_valid = 1;
      waitEv(0, tA);
      @(posedge clk); #1 cfg_valid = 0;
      waitEv(1, tD);
      chk("lat6", 16'(tD - tA), 16'(6 * per + 1));
      if (s == 0) chk("lat25", 16'(tD - tA), 16'd25);
      chk("nwr6", 16'(wq.size()), 16'd6);
      if (wq.size() == 6) chk("wr5_mode", 16'(wq[5]), 16'hB5A);
      wq.delete();
      iorCnt = 0;
      rd_channel = 2'd1;
      rd_valid = 1;
      waitEv(0, tA);
      @(posedge clk); #1 rd_valid = 0;
      waitEv(2, tD);
      chk("lat_rd", 16'(tD - tA), 16'(3 * per + 1));
      if (s == 0) chk("lat13", 16'(tD - tA), 16'd13);
      chk("rd_abcd", rd, 16'hABCD);
      chk("ior_cnt", 16'(iorCnt), 16'd2);
      chk("rd_nwr", 16'(wq.size()), 16'd1);
      if (wq.size() == 1) chk("rd_clr", 16'(wq[0]), 16'h0C00);
      setCfg(2'd3, 16'hFFFF, 16'h0000, 6'b000000, 1);
      rd_channel = 2'd3;
      cfg_valid = 1;
      rd_valid = 1;
      waitEv(0, tA);
      @(posedge clk); #1 cfg_valid = 0;
      waitEv(1, tD);
      waitEv(0, tR);
      chk("rd_after_cfg", 16'(tR - tD), 16'd1);
      @(posedge clk); #1 rd_valid = 0;
      waitEv(2, tD);
      chk("rd_ffff", rd, 16'hFFFF);
      setCfg(2'd0, 16'h5555, 16'h0010, 6'b000100, 1);
      cfg_valid = 1;
      waitEv(0, tA);
      @(posedge clk); #1 cfg_valid = 0;
      repeat (2 * per + 2) @(negedge clk);
      #2 chk("pre_rst_iow", iow, 0);
      rst = 1;
      #1 chk("arst_cs", cs, 1);
      chk("arst_iow", iow, 1);
      chk("arst_oe", oe, 0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      repeat (3) @(negedge clk);
      chk("post_rst_rdy", rdy, 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
